prb_gen: RTL and testbench

// - Random-source and precision block for early-terminating stochastic computing (SC).
// - Holds S_GROUPS W-bit maximal-length LFSRs whose states S[g] feed the SNG comparators (Bx > S).
// - From the binary operands Bxs it derives the precision needed for an exact result.
// - It outputs k_init, the early-termination cycle budget minus one, loaded by the downstream down-counter.

---
 rtl/prb_gen.sv | 110 +++++++++++
 tb/tb_prb_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/prb_gen.sv
// Random-source and precision block for early-terminating stochastic computing.
// Optional macro PRB_MASK_EN forces the low tz_reg bits of every RNG word to zero.
module prb_gen #(
    parameter int unsigned W        = 6,
    parameter int unsigned N        = 2,
    parameter int unsigned CORR     = 0,
    parameter int unsigned S_GROUPS = (CORR != 0) ? 1 : N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] Bxs [N],
    output logic [W-1:0] S [S_GROUPS],
    output logic [W-1:0] k_init
);

    localparam int unsigned TzW     = $clog2(W + 1);
    localparam int unsigned NumLfsr = (CORR != 0) ? 1 : S_GROUPS;
    localparam logic [W-1:0] Ones   = '1;

    // Maximal-length feedback taps (XAPP052), 0-based bit positions.
    function automatic logic [W-1:0] tap_mask();
        case (W)
            3:       return W'(16'h0006);
            4:       return W'(16'h000C);
            5:       return W'(16'h0014);
            6:       return W'(16'h0030);
            7:       return W'(16'h0060);
            8:       return W'(16'h00B8);
            9:       return W'(16'h0110);
            10:      return W'(16'h0240);
            11:      return W'(16'h0500);
            12:      return W'(16'h0829);
            13:      return W'(16'h100D);
            14:      return W'(16'h2015);
            15:      return W'(16'h6000);
            16:      return W'(16'hD008);
            default: return W'(16'h0030);
        endcase
    endfunction

    localparam logic [W-1:0] Taps = tap_mask();

    logic [TzW-1:0] tz_cur;
    logic [TzW-1:0] tz_min;
    logic [TzW-1:0] p;
    logic [W-1:0]   k_d;
    logic [W-1:0]   low_mask;

    always_comb begin
        tz_min = TzW'(W);
        tz_cur = TzW'(W);
        for (int i = 0; i < int'(N); i++) begin
            tz_cur = TzW'(W);
            for (int b = int'(W) - 1; b >= 0; b--) begin
                if (Bxs[i][b]) begin
                    tz_cur = TzW'(b);
                end
            end
            if (tz_cur < tz_min) begin
                tz_min = tz_cur;
            end
        end
        p   = TzW'(W) - tz_min;
        // Shifting an all-ones word by p and inverting gives 2^p - 1 without a W+1 bit carry.
        k_d = ~(Ones << p);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_init <= '0;
        end else begin
            k_init <= k_d;
        end
    end

`ifdef PRB_MASK_EN
    logic [TzW-1:0] tz_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tz_reg <= '0;
        end else begin
            tz_reg <= tz_min;
        end
    end

    assign low_mask = ~(Ones << tz_reg);
`else
    assign low_mask = '0;
`endif

    for (genvar g = 0; g < NumLfsr; g++) begin : g_lfsr
        logic [W-1:0] lfsr_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lfsr_q <= W'(g + 1);
            end else begin
                lfsr_q <= {lfsr_q[W-2:0], ^(lfsr_q & Taps)};
            end
        end
    end

    // With shared RNG every group taps the single LFSR.
    for (genvar g = 0; g < S_GROUPS; g++) begin : g_out
        localparam int unsigned Src = g % NumLfsr;
        assign S[g] = g_lfsr[Src].lfsr_q & ~low_mask;
    end

endmodule

// File: tb/tb_prb_gen.sv
// Self-checking bench for prb_gen: directed cases, LFSR stepping, async reset and random Bxs.
module tb_prb_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] bxs [2];
    logic [5:0] s [2];
    logic [5:0] k;
    logic [5:0] s_c [1];
    logic [5:0] k_c;

    int checks = 0;
    int errors = 0;

    // Reference: bit stream a[t+6] = a[t] ^ a[t+1]; LFSR state at step n is a[n..n+5], MSB first.
    logic       a [68];
    int         idx [2];
    int         tzr;
    logic [5:0] kexp;

    always #5 clk = ~clk;

    prb_gen #(.W(6), .N(2), .CORR(0), .S_GROUPS(2)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .Bxs    (bxs),
        .S      (s),
        .k_init (k)
    );

    prb_gen #(.W(6), .N(2), .CORR(1), .S_GROUPS(1)) u_dut_corr (
        .clk    (clk),
        .rst    (rst),
        .Bxs    (bxs),
        .S      (s_c),
        .k_init (k_c)
    );

    function automatic logic [5:0] st_at(input int n);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[5-i] = a[(n % 63) + i];
        return r;
    endfunction

    function automatic int find_idx(input logic [5:0] v);
        for (int n = 0; n < 63; n++) if (st_at(n) == v) return n;
        return 0;
    endfunction

    function automatic int tz_of(input logic [5:0] v);
        int x;
        int t;
        x = int'(v);
        if (x == 0) return 6;
        t = 0;
        while (x % 2 == 0) begin
            x = x / 2;
            t++;
        end
        return t;
    endfunction

    function automatic logic [5:0] masked(input logic [5:0] v, input int tz);
        logic [6:0] m;
        m = 7'((1 << tz) - 1);
`ifdef PRB_MASK_EN
        return v & ~m[5:0];
`else
        return v | (m[5:0] & 6'b0);
`endif
    endfunction

    task automatic reset_model();
        idx[0] = find_idx(6'd1);
        idx[1] = find_idx(6'd2);
        tzr    = 0;
        kexp   = 6'd0;
    endtask

    task automatic tick();
        int tm;
        @(posedge clk);
        if (rst) begin
            reset_model();
        end else begin
            idx[0] = (idx[0] + 1) % 63;
            idx[1] = (idx[1] + 1) % 63;
            tm     = (tz_of(bxs[0]) < tz_of(bxs[1])) ? tz_of(bxs[0]) : tz_of(bxs[1]);
            kexp   = 6'((1 << (6 - tm)) - 1);
            tzr    = tm;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bxs[0] = 6'b001100;
        bxs[1] = 6'b011000;
        #1 rst = 1'b1;
        #1;
        reset_model();
        checks++; if (s[0] !== 6'd1) begin errors++; $display("FAIL reset_s0 got %b want %b", s[0], 6'd1); end
        checks++; if (s[1] !== 6'd2) begin errors++; $display("FAIL reset_s1 got %b want %b", s[1], 6'd2); end
        checks++; if (k !== 6'd0) begin errors++; $display("FAIL reset_k got %b want %b", k, 6'd0); end
        checks++; if (s_c[0] !== 6'd1) begin errors++; $display("FAIL reset_corr_s got %b want %b", s_c[0], 6'd1); end
        checks++; if (k_c !== 6'd0) begin errors++; $display("FAIL reset_corr_k got %b want %b", k_c, 6'd0); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [5:0] in0 [3];
        logic [5:0] in1 [3];
        logic [5:0] want [3];
        in0  = '{6'b001100, 6'b000000, 6'b000000};
        in1  = '{6'b011000, 6'b111111, 6'b000000};
        want = '{6'b001111, 6'b111111, 6'b000000};
        for (int i = 0; i < 3; i++) begin
            bxs[0] = in0[i];
            bxs[1] = in1[i];
            tick();
            checks++;
            if (k !== want[i]) begin
                errors++;
                $display("FAIL directed_k[%0d] got %b want %b", i, k, want[i]);
            end
            checks++;
            if (k_c !== want[i]) begin
                errors++;
                $display("FAIL directed_corr_k[%0d] got %b want %b", i, k_c, want[i]);
            end
        end
`ifdef PRB_MASK_EN
        checks++; if (s[0] !== 6'd0) begin errors++; $display("FAIL mask_zero_s0 got %b want 000000", s[0]); end
        checks++; if (s[1] !== 6'd0) begin errors++; $display("FAIL mask_zero_s1 got %b want 000000", s[1]); end
`endif
    endtask

    task automatic test_lfsr();
        logic [5:0] seq [7];
        int n;
        seq = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100001, 6'b000011};
        bxs[0] = 6'b000001;
        bxs[1] = 6'b000001;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            checks++;
            if (s[0] !== seq[i]) begin errors++; $display("FAIL lfsr_s0[%0d] got %b want %b", i, s[0], seq[i]); end
            checks++;
            if (s_c[0] !== seq[i]) begin errors++; $display("FAIL lfsr_corr[%0d] got %b want %b", i, s_c[0], seq[i]); end
            if (i == 0) begin
                checks++; if (s[1] !== 6'b000010) begin errors++; $display("FAIL lfsr_s1[0] got %b want 000010", s[1]); end
            end
            if (i == 1) begin
                checks++; if (s[1] !== 6'b000100) begin errors++; $display("FAIL lfsr_s1[1] got %b want 000100", s[1]); end
                checks++; if (k !== 6'b111111) begin errors++; $display("FAIL lfsr_k got %b want 111111", k); end
            end
        end
        n = 6;
        while (s[0] !== 6'd1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != 63) begin errors++; $display("FAIL lfsr_period got %0d want 63", n); end
    endtask

    task automatic test_reset_mid();
        bxs[0] = 6'b000001;
        bxs[1] = 6'b000001;
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (s[0] !== 6'd1) begin errors++; $display("FAIL midrst_s0 got %b want 000001", s[0]); end
        checks++; if (s[1] !== 6'd2) begin errors++; $display("FAIL midrst_s1 got %b want 000010", s[1]); end
        checks++; if (k !== 6'd0) begin errors++; $display("FAIL midrst_k got %b want 000000", k); end
        checks++; if (s_c[0] !== 6'd1) begin errors++; $display("FAIL midrst_corr got %b want 000001", s_c[0]); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (s[0] !== 6'd2) begin errors++; $display("FAIL resume_s0 got %b want 000010", s[0]); end
        checks++; if (s[1] !== 6'd4) begin errors++; $display("FAIL resume_s1 got %b want 000100", s[1]); end
        checks++; if (k !== 6'd63) begin errors++; $display("FAIL resume_k got %b want 111111", k); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [5:0]  e0;
        logic [5:0]  e1;
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < 2; i++) begin
                r = $urandom_range(0, 63) << $urandom_range(0, 5);
                bxs[i] = r[5:0];
            end
            tick();
            e0 = masked(st_at(idx[0]), tzr);
            e1 = masked(st_at(idx[1]), tzr);
            checks++; if (k !== kexp) begin errors++; $display("FAIL rand_k[%0d] got %b want %b", c, k, kexp); end
            checks++; if (k_c !== kexp) begin errors++; $display("FAIL rand_corr_k[%0d] got %b want %b", c, k_c, kexp); end
            checks++; if (s[0] !== e0) begin errors++; $display("FAIL rand_s0[%0d] got %b want %b", c, s[0], e0); end
            checks++; if (s[1] !== e1) begin errors++; $display("FAIL rand_s1[%0d] got %b want %b", c, s[1], e1); end
            checks++; if (s_c[0] !== e0) begin errors++; $display("FAIL rand_corr_s[%0d] got %b want %b", c, s_c[0], e0); end
`ifndef PRB_MASK_EN
            checks++;
            if (s[0] === 6'd0 || s[1] === 6'd0) begin
                errors++;
                $display("FAIL rand_nonzero[%0d] got %b %b want nonzero", c, s[0], s[1]);
            end
`endif
        end
    endtask

    initial begin
        for (int t = 0; t < 5; t++) a[t] = 1'b0;
        a[5] = 1'b1;
        for (int t = 0; t < 62; t++) a[t+6] = a[t] ^ a[t+1];
        reset_model();
        test_reset();
        test_directed();
        test_lfsr();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
